// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame sequencer: FSM state
// encodings and a counter-width helper.
package uart_rx_frame_ctrl_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_baud_gen.sv
// Baud counter: free-runs 0..CLKS_PER_BIT-1, restarts from 0 whenever
// clear is high, and flags the half-bit and full-bit points.
module uart_baud_gen
   import uart_rx_frame_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic half_tick,
   output logic full_tick
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise wrap at the end of a bit period.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == FULL_CNT)) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Ticks decode the registered count only, so they never depend on clear.
   assign half_tick = (cnt_q == HALF_CNT);
   assign full_tick = (cnt_q == FULL_CNT);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive sequencer: synchronises the line, walks start/data/parity/stop,
// strobes the external shift and holding registers, and owns the valid/ready
// handshake together with parity, framing and sticky overrun flags.
module uart_rx_frame_ctrl
   import uart_rx_frame_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   input  logic rx_ready,
   input  logic clear_err,
   output logic rx_shift,
   output logic sample_bit,
   output logic load_hold,
   output logic rx_valid,
   output logic parity_err,
   output logic frame_err,
   output logic overrun,
   output logic busy
);

   localparam logic PAR_EN  = (PARITY_EN != 0);
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic       rx_meta_q, rxs_q;
   logic [2:0] state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic       acc_q, acc_d;
   logic       perr_q, perr_d;
   logic       rx_shift_q, rx_shift_d;
   logic       sample_bit_q, sample_bit_d;
   logic       load_hold_q, load_hold_d;
   logic       rx_valid_q, rx_valid_d;
   logic       parity_err_q, parity_err_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;
   logic       busy_q, busy_d;
   logic       half_tick, full_tick, cnt_clear;

   // The counter restarts on every state entry and is held at 0 while idle.
   assign cnt_clear = (state_d != state_q) || (state_q == ST_IDLE);

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk       (clk),
      .reset     (reset),
      .clear     (cnt_clear),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= data_in;
         rxs_q     <= rx_meta_q;
      end
   end

   // Frame FSM plus handshake/flag next-state logic.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      acc_d        = acc_q;
      perr_d       = perr_q;
      rx_shift_d   = 1'b0;
      sample_bit_d = sample_bit_q;
      load_hold_d  = 1'b0;
      rx_valid_d   = rx_valid_q & ~rx_ready;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q & ~clear_err;
      case (state_q)
         ST_IDLE: begin
            if (!rxs_q) state_d = ST_START;
         end
         ST_START: begin
            bit_cnt_d = '0;
            acc_d     = 1'b0;
            perr_d    = 1'b0;
            if (half_tick) state_d = rxs_q ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (full_tick) begin
               rx_shift_d   = 1'b1;
               sample_bit_d = rxs_q;
               acc_d        = acc_q ^ rxs_q;
               bit_cnt_d    = bit_cnt_q + 4'd1;
               if (bit_cnt_q == LAST_BIT) state_d = PAR_EN ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (full_tick) begin
               perr_d  = rxs_q ^ acc_q ^ PAR_ODD;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (full_tick) begin
               // A pending, unaccepted frame is kept; the new one is dropped.
               if (rx_valid_q && !rx_ready) begin
                  overrun_d = 1'b1;
               end else begin
                  load_hold_d  = 1'b1;
                  rx_valid_d   = 1'b1;
                  parity_err_d = PAR_EN & perr_q;
                  frame_err_d  = ~rxs_q;
               end
               state_d = rxs_q ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (rxs_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         acc_q        <= 1'b0;
         perr_q       <= 1'b0;
         rx_shift_q   <= 1'b0;
         sample_bit_q <= 1'b0;
         load_hold_q  <= 1'b0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         acc_q        <= acc_d;
         perr_q       <= perr_d;
         rx_shift_q   <= rx_shift_d;
         sample_bit_q <= sample_bit_d;
         load_hold_q  <= load_hold_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
      end
   end

   assign rx_shift   = rx_shift_q;
   assign sample_bit = sample_bit_q;
   assign load_hold  = load_hold_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: serial frames are driven on data_in and the
// strobes, flags and handshake are compared with a frame-level model.
module tb_uart_rx_frame_ctrl;

   localparam int CPB   = 16;
   localparam int DBITS = 8;
   localparam logic ODD = 1'b0;

   logic clk = 1'b0;
   logic reset, data_in, rx_ready, clear_err;
   logic rx_shift, sample_bit, load_hold, rx_valid, parity_err, frame_err, overrun, busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Observation of the strobes.
   logic samp_q[$];
   int   load_cnt = 0;
   logic ld_perr, ld_ferr, ld_valid;

   // Frame-level reference state.
   logic m_valid, m_ovr, m_perr, m_ferr;
   int   m_loads;

   uart_rx_frame_ctrl #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DBITS), .PARITY_EN(1), .PARITY_ODD(0)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .rx_ready(rx_ready),
      .clear_err(clear_err), .rx_shift(rx_shift), .sample_bit(sample_bit),
      .load_hold(load_hold), .rx_valid(rx_valid), .parity_err(parity_err),
      .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_shift) samp_q.push_back(sample_bit);
      if (load_hold) begin
         load_cnt++;
         ld_perr  = parity_err;
         ld_ferr  = frame_err;
         ld_valid = rx_valid;
      end
   end

   task automatic model_reset();
      m_valid = 0; m_ovr = 0; m_perr = 0; m_ferr = 0; m_loads = load_cnt;
   endtask

   // Outcome of one complete frame, rx_ready held constant across it.
   task automatic model_frame(input logic [7:0] d, input logic pb, input logic sb, input logic rdy);
      if (rdy) m_valid = 0;
      if (m_valid && !rdy) begin
         m_ovr = 1;
      end else begin
         m_valid = 1;
         m_perr  = (^d) ^ pb ^ ODD;
         m_ferr  = !sb;
         m_loads++;
      end
      if (rdy) m_valid = 0;
   endtask

   task automatic drive_bit(input logic b);
      data_in = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int low_hold);
      drive_bit(1'b0);
      for (int i = 0; i < DBITS; i++) drive_bit(d[i]);
      drive_bit(pb);
      drive_bit(sb);
      if (!sb) repeat (low_hold) @(negedge clk);
      data_in = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1; data_in = 1; rx_ready = 1; clear_err = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_shift, sample_bit, load_hold, rx_valid, parity_err, frame_err, overrun, busy} !== 8'h00)
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {rx_shift, sample_bit, load_hold, rx_valid, parity_err, frame_err, overrun, busy});
      else n_pass++;
      reset = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
      else n_pass++;
      model_reset();
   endtask

   task automatic test_frame_a5();
      logic [7:0] exp_bits;
      exp_bits = 8'hA5;
      samp_q.delete();
      rx_ready = 1;
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      model_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (samp_q.size() !== DBITS) $display("FAIL a5_shift_count: got %0d expected %0d", samp_q.size(), DBITS);
      else n_pass++;
      for (int i = 0; i < DBITS && i < samp_q.size(); i++) begin
         n_checks++;
         if (samp_q[i] !== exp_bits[i]) $display("FAIL a5_bit%0d: got %b expected %b", i, samp_q[i], exp_bits[i]);
         else n_pass++;
      end
      n_checks++;
      if (load_cnt !== m_loads) $display("FAIL a5_load: got %0d expected %0d", load_cnt, m_loads);
      else n_pass++;
      n_checks++;
      if ({ld_valid, ld_perr, ld_ferr} !== 3'b100)
         $display("FAIL a5_flags: got %b expected 100", {ld_valid, ld_perr, ld_ferr});
      else n_pass++;
   endtask

   task automatic test_glitch();
      int l0;
      l0 = load_cnt;
      samp_q.delete();
      data_in = 0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL glitch_start_busy: got %b expected 1", busy);
      else n_pass++;
      data_in = 1;
      repeat (3 * CPB) @(negedge clk);
      n_checks++;
      if ({samp_q.size() != 0, load_cnt != l0, busy} !== 3'b000)
         $display("FAIL glitch_idle: shifts %0d loads %0d busy %b expected 0 0 0", samp_q.size(), load_cnt - l0, busy);
      else n_pass++;
   endtask

   task automatic test_parity();
      rx_ready = 1;
      send_frame(8'h01, 1'b0, 1'b1, 0);
      model_frame(8'h01, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if ({load_cnt == m_loads, ld_valid, ld_perr} !== {2'b11, m_perr})
         $display("FAIL parity_bad: loads_ok %b valid %b perr %b expected 1 1 %b", load_cnt == m_loads, ld_valid, ld_perr, m_perr);
      else n_pass++;
      send_frame(8'h03, 1'b0, 1'b1, 0);
      model_frame(8'h03, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (parity_err !== m_perr) $display("FAIL parity_cleared: got %b expected %b", parity_err, m_perr);
      else n_pass++;
   endtask

   task automatic test_break();
      samp_q.delete();
      rx_ready = 1;
      drive_bit(1'b0);
      for (int i = 0; i < DBITS; i++) drive_bit(8'h3C >> i);
      drive_bit(^8'h3C);
      drive_bit(1'b0);
      repeat (40) @(negedge clk);
      model_frame(8'h3C, ^8'h3C, 1'b0, 1'b1);
      n_checks++;
      if ({ld_ferr, frame_err, load_cnt == m_loads} !== {m_ferr, m_ferr, 1'b1})
         $display("FAIL break_frame_err: ld %b now %b loads_ok %b expected %b", ld_ferr, frame_err, load_cnt == m_loads, m_ferr);
      else n_pass++;
      n_checks++;
      if ({busy, samp_q.size() == DBITS} !== 2'b11)
         $display("FAIL break_held: busy %b shifts %0d expected 1 %0d", busy, samp_q.size(), DBITS);
      else n_pass++;
      data_in = 1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL break_release: got busy %b expected 0", busy);
      else n_pass++;
      repeat (2 * CPB) @(negedge clk);
      n_checks++;
      if ({samp_q.size() == DBITS, load_cnt == m_loads} !== 2'b11)
         $display("FAIL break_no_restart: shifts %0d loads %0d expected %0d %0d", samp_q.size(), load_cnt, DBITS, m_loads);
      else n_pass++;
   endtask

   task automatic test_overrun();
      rx_ready = 0;
      send_frame(8'h96, 1'b1, 1'b1, 0);
      model_frame(8'h96, 1'b1, 1'b1, 1'b0);
      send_frame(8'h11, 1'b0, 1'b1, 0);
      model_frame(8'h11, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (load_cnt !== m_loads) $display("FAIL ovr_loads: got %0d expected %0d", load_cnt, m_loads);
      else n_pass++;
      n_checks++;
      if ({rx_valid, overrun, parity_err, frame_err} !== {m_valid, m_ovr, m_perr, m_ferr})
         $display("FAIL ovr_state: got %b expected %b", {rx_valid, overrun, parity_err, frame_err}, {m_valid, m_ovr, m_perr, m_ferr});
      else n_pass++;
      clear_err = 1;
      @(negedge clk);
      clear_err = 0;
      m_ovr = 0;
      n_checks++;
      if ({overrun, rx_valid} !== {m_ovr, m_valid})
         $display("FAIL ovr_clear: got %b expected %b", {overrun, rx_valid}, {m_ovr, m_valid});
      else n_pass++;
      rx_ready = 1;
      @(negedge clk);
      m_valid = 0;
      n_checks++;
      if (rx_valid !== m_valid) $display("FAIL ovr_handshake: got %b expected %b", rx_valid, m_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'h5A;
      rx_ready = 1;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i]);
      data_in = d[3];
      repeat (CPB / 2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy);
      else n_pass++;
      #2 reset = 1;
      #1;
      n_checks++;
      if ({rx_shift, sample_bit, load_hold, rx_valid, parity_err, frame_err, overrun, busy} !== 8'h00)
         $display("FAIL mid_async_reset: got %b expected 00000000",
                  {rx_shift, sample_bit, load_hold, rx_valid, parity_err, frame_err, overrun, busy});
      else n_pass++;
      data_in = 1;
      repeat (3) @(negedge clk);
      reset = 0;
      model_reset();
      repeat (2 * CPB) @(negedge clk);
      n_checks++;
      if (load_cnt !== m_loads) $display("FAIL mid_no_partial_load: got %0d expected %0d", load_cnt, m_loads);
      else n_pass++;
      samp_q.delete();
      send_frame(d, ^d, 1'b1, 0);
      model_frame(d, ^d, 1'b1, 1'b1);
      n_checks++;
      if (samp_q.size() !== DBITS) $display("FAIL mid_5a_count: got %0d expected %0d", samp_q.size(), DBITS);
      else n_pass++;
      for (int i = 0; i < DBITS && i < samp_q.size(); i++) begin
         n_checks++;
         if (samp_q[i] !== d[i]) $display("FAIL mid_5a_bit%0d: got %b expected %b", i, samp_q[i], d[i]);
         else n_pass++;
      end
      n_checks++;
      if ({load_cnt == m_loads, ld_perr, ld_ferr} !== {1'b1, m_perr, m_ferr})
         $display("FAIL mid_5a_flags: got %b expected %b", {load_cnt == m_loads, ld_perr, ld_ferr}, {1'b1, m_perr, m_ferr});
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic pb, sb, rdy;
      for (int f = 0; f < 14; f++) begin
         d   = 8'($urandom);
         pb  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
         sb  = ($urandom_range(0, 5) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         rx_ready = rdy;
         samp_q.delete();
         send_frame(d, pb, sb, $urandom_range(0, 20));
         model_frame(d, pb, sb, rdy);
         n_checks++;
         if (samp_q.size() !== DBITS) $display("FAIL rnd%0d_count: got %0d expected %0d", f, samp_q.size(), DBITS);
         else n_pass++;
         for (int i = 0; i < DBITS && i < samp_q.size(); i++) begin
            n_checks++;
            if (samp_q[i] !== d[i]) $display("FAIL rnd%0d_bit%0d: got %b expected %b", f, i, samp_q[i], d[i]);
            else n_pass++;
         end
         n_checks++;
         if (load_cnt !== m_loads) $display("FAIL rnd%0d_loads: got %0d expected %0d", f, load_cnt, m_loads);
         else n_pass++;
         n_checks++;
         if ({rx_valid, overrun, parity_err, frame_err, busy} !== {m_valid, m_ovr, m_perr, m_ferr, 1'b0})
            $display("FAIL rnd%0d_flags: got %b expected %b", f, {rx_valid, overrun, parity_err, frame_err, busy},
                     {m_valid, m_ovr, m_perr, m_ferr, 1'b0});
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_glitch();
      test_parity();
      test_break();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
